// File: rtl/tinyalu_dispatch.sv
// TinyALU command dispatcher: runs add/and/xor in one cycle, hands multiply to
// the external three-stage multiplier, and returns one 16-bit result per
// start/done handshake with an error flag for reserved opcodes and timeouts.
module tinyalu_dispatch #(
  parameter int unsigned MULT_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  output logic        done,
  output logic [15:0] result,
  output logic        err,
  output logic        busy,
  output logic [7:0]  mult_A,
  output logic [7:0]  mult_B,
  output logic        start_mult,
  input  logic        done_mult,
  input  logic [15:0] result_mult
);

  typedef enum logic [1:0] {StIdle, StMul, StWaitLow} state_e;

  localparam logic [2:0] OpNop = 3'b000;
  localparam logic [2:0] OpAdd = 3'b001;
  localparam logic [2:0] OpAnd = 3'b010;
  localparam logic [2:0] OpXor = 3'b011;
  localparam logic [2:0] OpMul = 3'b100;

  // Counter value at which the multiply is abandoned: seen at edge E(MULT_TIMEOUT).
  localparam logic [7:0] CntLast = 8'(MULT_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] result_q, result_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;
  logic        start_mult_q, start_mult_d;
  logic [7:0]  mult_a_q, mult_a_d;
  logic [7:0]  mult_b_q, mult_b_d;

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    result_d     = result_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    start_mult_d = start_mult_q;
    mult_a_d     = mult_a_q;
    mult_b_d     = mult_b_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (op == OpMul) begin
            mult_a_d     = A;
            mult_b_d     = B;
            start_mult_d = 1'b1;
            cnt_d        = 8'h00;
            state_d      = StMul;
          end else begin
            done_d  = 1'b1;
            state_d = StWaitLow;
            case (op)
              OpAdd:   result_d = {7'b0, {1'b0, A} + {1'b0, B}};
              OpAnd:   result_d = {8'b0, A & B};
              OpXor:   result_d = {8'b0, A ^ B};
              OpNop:   result_d = 16'h0000;
              default: begin
                result_d = 16'h0000;
                err_d    = 1'b1;
              end
            endcase
          end
        end
      end
      StMul: begin
        if (done_mult) begin
          result_d     = result_mult;
          done_d       = 1'b1;
          start_mult_d = 1'b0;
          state_d      = StWaitLow;
        end else if (cnt_q == CntLast) begin
          result_d     = 16'h0000;
          done_d       = 1'b1;
          err_d        = 1'b1;
          start_mult_d = 1'b0;
          state_d      = StWaitLow;
        end else begin
          cnt_d = cnt_q + 8'h01;
        end
      end
      StWaitLow: begin
        // A held start must not re-trigger; wait for the requester to let go.
        if (!start) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      cnt_q        <= 8'h00;
      result_q     <= 16'h0000;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      start_mult_q <= 1'b0;
      mult_a_q     <= 8'h00;
      mult_b_q     <= 8'h00;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      result_q     <= result_d;
      done_q       <= done_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
      start_mult_q <= start_mult_d;
      mult_a_q     <= mult_a_d;
      mult_b_q     <= mult_b_d;
    end
  end

  assign done       = done_q;
  assign result     = result_q;
  assign err        = err_q;
  assign busy       = busy_q;
  assign start_mult = start_mult_q;
  assign mult_A     = mult_a_q;
  assign mult_B     = mult_b_q;

endmodule

// File: tb/tb_tinyalu_dispatch.sv
// Directed bench for tinyalu_dispatch with a small three-stage multiplier model.
module tb_tinyalu_dispatch;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [2:0]  op;
  logic [7:0]  A;
  logic [7:0]  B;
  logic        done;
  logic [15:0] result;
  logic        err;
  logic        busy;
  logic [7:0]  mult_A;
  logic [7:0]  mult_B;
  logic        start_mult;
  logic        done_mult;
  logic [15:0] result_mult;

  logic        mult_en;
  logic        stray;
  logic        m_busy;
  logic [1:0]  m_cnt;
  logic        m_done;
  logic [15:0] m_prod;

  int n_checks = 0;
  int n_fail   = 0;

  tinyalu_dispatch #(.MULT_TIMEOUT(15)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .op         (op),
    .A          (A),
    .B          (B),
    .done       (done),
    .result     (result),
    .err        (err),
    .busy       (busy),
    .mult_A     (mult_A),
    .mult_B     (mult_B),
    .start_mult (start_mult),
    .done_mult  (done_mult),
    .result_mult(result_mult)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiplier model: operands taken at E1, done_mult raised at E5.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy <= 1'b0;
      m_cnt  <= 2'd0;
      m_done <= 1'b0;
      m_prod <= 16'h0000;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (m_cnt == 2'd3) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
        end else begin
          m_cnt <= m_cnt + 2'd1;
        end
      end else if (start_mult && !m_done) begin
        m_busy <= 1'b1;
        m_cnt  <= 2'd0;
        m_prod <= {8'h00, mult_A} * {8'h00, mult_B};
      end
    end
  end

  assign done_mult   = (mult_en & m_done) | stray;
  assign result_mult = stray ? 16'hBEEF : m_prod;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold start until done (bounded); returns the edge index of done (E0 = 0).
  task automatic run_until_done(input int budget, input logic [7:0] ea, input logic [7:0] eb,
                                output int edge_idx, output int sm_cycles,
                                output logic ops_stable);
    logic seen;
    seen = 1'b0;
    edge_idx = 0;
    sm_cycles = 0;
    ops_stable = 1'b1;
    while (!seen && edge_idx < budget) begin
      tick();
      if (start_mult) sm_cycles++;
      if (mult_A !== ea || mult_B !== eb) ops_stable = 1'b0;
      if (done) seen = 1'b1;
      else edge_idx++;
    end
  endtask

  int   idx;
  int   smc;
  logic stable;

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    op      = 3'b000;
    A       = 8'h00;
    B       = 8'h00;
    mult_en = 1'b1;
    stray   = 1'b0;
    #12;
    check_eq("rst_done", {31'b0, done}, 32'd0);
    check_eq("rst_busy", {31'b0, busy}, 32'd0);
    check_eq("rst_result", {16'b0, result}, 32'h0);
    check_eq("rst_start_mult", {31'b0, start_mult}, 32'd0);
    reset_n = 1'b1;
    tick();

    // Add with carry-out into bit 8.
    start = 1'b1; op = 3'b001; A = 8'hFF; B = 8'h01;
    tick();
    check_eq("add_done", {31'b0, done}, 32'd1);
    check_eq("add_result", {16'b0, result}, 32'h0100);
    check_eq("add_err", {31'b0, err}, 32'd0);
    check_eq("add_busy", {31'b0, busy}, 32'd1);
    start = 1'b0;
    tick();
    check_eq("add_done_width", {31'b0, done}, 32'd0);
    check_eq("add_idle_busy", {31'b0, busy}, 32'd0);

    // Multiply through the model.
    start = 1'b1; op = 3'b100; A = 8'hFF; B = 8'hFF;
    run_until_done(40, 8'hFF, 8'hFF, idx, smc, stable);
    check_eq("mul_latency", idx, 32'd6);
    check_eq("mul_start_mult_cycles", smc, 32'd6);
    check_eq("mul_ops_stable", {31'b0, stable}, 32'd1);
    check_eq("mul_result", {16'b0, result}, 32'hFE01);
    check_eq("mul_err", {31'b0, err}, 32'd0);
    check_eq("mul_start_mult_low", {31'b0, start_mult}, 32'd0);
    start = 1'b0;
    tick();
    check_eq("mul_done_width", {31'b0, done}, 32'd0);
    check_eq("mul_result_held", {16'b0, result}, 32'hFE01);

    // Reserved opcode.
    start = 1'b1; op = 3'b110; A = 8'h12; B = 8'h34;
    tick();
    check_eq("rsv_done", {31'b0, done}, 32'd1);
    check_eq("rsv_err", {31'b0, err}, 32'd1);
    check_eq("rsv_result", {16'b0, result}, 32'h0);
    check_eq("rsv_start_mult", {31'b0, start_mult}, 32'd0);
    start = 1'b0;
    tick();
    check_eq("rsv_err_width", {31'b0, err}, 32'd0);

    // Multiply timeout with the multiplier silent.
    mult_en = 1'b0;
    start = 1'b1; op = 3'b100; A = 8'h05; B = 8'h06;
    run_until_done(40, 8'h05, 8'h06, idx, smc, stable);
    check_eq("to_latency", idx, 32'd15);
    check_eq("to_err", {31'b0, err}, 32'd1);
    check_eq("to_result", {16'b0, result}, 32'h0);
    check_eq("to_start_mult", {31'b0, start_mult}, 32'd0);
    check_eq("to_ops_stable", {31'b0, stable}, 32'd1);
    start = 1'b0;
    tick();
    mult_en = 1'b1;
    repeat (6) tick();

    // Handshake: start held past done, then a back-to-back xor.
    start = 1'b1; op = 3'b001; A = 8'h10; B = 8'h20;
    tick();
    check_eq("hs_done", {31'b0, done}, 32'd1);
    check_eq("hs_result", {16'b0, result}, 32'h0030);
    op = 3'b011; A = 8'hAA; B = 8'h55;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("hs_hold_no_done", {31'b0, done}, 32'd0);
      check_eq("hs_hold_busy", {31'b0, busy}, 32'd1);
    end
    check_eq("hs_hold_result", {16'b0, result}, 32'h0030);
    start = 1'b0;
    tick();
    check_eq("hs_release_busy", {31'b0, busy}, 32'd0);
    start = 1'b1; op = 3'b011; A = 8'hF0; B = 8'h3C;
    tick();
    check_eq("xor_done", {31'b0, done}, 32'd1);
    check_eq("xor_result", {16'b0, result}, 32'h00CC);
    start = 1'b0;
    tick();

    // Reset in the middle of a multiply.
    start = 1'b1; op = 3'b100; A = 8'h07; B = 8'h09;
    repeat (4) tick();
    check_eq("rm_pre_start_mult", {31'b0, start_mult}, 32'd1);
    reset_n = 1'b0;
    start = 1'b0;
    #1;
    check_eq("rm_start_mult", {31'b0, start_mult}, 32'd0);
    check_eq("rm_busy", {31'b0, busy}, 32'd0);
    check_eq("rm_done", {31'b0, done}, 32'd0);
    check_eq("rm_result", {16'b0, result}, 32'h0);
    check_eq("rm_mult_A", {24'b0, mult_A}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    stray = 1'b1;
    tick();
    stray = 1'b0;
    check_eq("stray_no_done", {31'b0, done}, 32'd0);
    check_eq("stray_result", {16'b0, result}, 32'h0);
    tick();
    check_eq("stray_no_done_late", {31'b0, done}, 32'd0);
    start = 1'b1; op = 3'b001; A = 8'h02; B = 8'h03;
    tick();
    check_eq("post_add_done", {31'b0, done}, 32'd1);
    check_eq("post_add_result", {16'b0, result}, 32'h0005);
    start = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tinyalu_dispatch.md
# tinyalu_dispatch

Command front-end for the TinyALU datapath: accepts one operation at a time from the requester under the start/done handshake. Add, and and xor are executed internally in one cycle. Multiply is handed to the downstream three-stage pipelined multiplier, and its `result_mult`/`done_mult` are collected. Delivers a single 16-bit result with a one-cycle `done` pulse and flags illegal opcodes and multiplier timeouts.

## Interface
- `MULT_TIMEOUT`, default 15: maximum number of cycles spent in MUL before the operation is aborted with `err`. Legal range 8..255.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: requester command strobe. Held high, with `op`/`A`/`B` stable, until `done` is seen.
- `op` in 3: 000 no_op, 001 add, 010 and, 011 xor, 100 mul, 101–111 reserved.
- `A` in 8: operand A.
- `B` in 8: operand B.
- `done` out 1: one-cycle completion pulse.
- `result` out 16: operation result. Valid while `done`=1 and held until the next completion.
- `err` out 1: asserted only together with `done`, for a reserved opcode or a multiply timeout.
- `busy` out 1: high in every state other than IDLE.
- `mult_A` out 8: registered operand A to the multiplier.
- `mult_B` out 8: registered operand B to the multiplier.
- `start_mult` out 1: multiplier start, held high until `done_mult` is sampled.
- `done_mult` in 1: multiplier completion, a one-cycle pulse.
- `result_mult` in 16: multiplier product, valid while `done_mult`=1.

## Operation
- States: IDLE, MUL, WAIT_LOW.
- Reset (async): state=IDLE. `done`, `err`, `busy`, `start_mult` = 0. `result`=16'h0000. `mult_A`=`mult_B`=8'h00. Timeout counter=0.
- IDLE, `start`=0: stay in IDLE. `done_mult` is ignored.
- IDLE, `start`=1, op in {000,001,010,011} or reserved: perform the registered update below, then go to WAIT_LOW.
  - `done`=1.
  - `result` per op:
    - add: `{7'b0, A+B}`, with the 9-bit sum zero-extended.
    - and: `{8'b0, A&B}`.
    - xor: `{8'b0, A^B}`.
    - no_op and reserved: 16'h0000.
  - `err`=1 for reserved opcodes only.
- IDLE, `start`=1, op=100: `mult_A`<=A, `mult_B`<=B, `start_mult`<=1, counter<=0, go to MUL.
- MUL, `done_mult`=1: `result`<=`result_mult`, `done`<=1, `err`<=0, `start_mult`<=0, go to WAIT_LOW.
- MUL, `done_mult`=0, counter=MULT_TIMEOUT-1: `result`<=0, `done`<=1, `err`<=1, `start_mult`<=0, go to WAIT_LOW.
- MUL, otherwise: counter increments.
- `mult_A`/`mult_B` stay constant throughout MUL. The multiplier resamples its inputs every cycle, so they must not change.
- WAIT_LOW: `done`/`err` return to 0 after one cycle. Return to IDLE on the first edge where `start`=0. If `start` is still high, no new command is accepted.
- `done_mult` arriving in any state other than MUL is ignored and does not change `result`.
- `op`, `A` and `B` are sampled only in IDLE. Changes during MUL or WAIT_LOW have no effect.

## Timing
- Let E0 be the edge at which IDLE samples `start`=1.
- Single-cycle ops: `done` and `result` are registered at E0 and visible during the cycle after E0 (latency 1).
- Multiply, nominal latency against the downstream multiplier:
  - `start_mult` rises at E0.
  - The multiplier registers its operands at E1 and raises `done_mult` at E5.
  - The dispatcher samples `done_mult` at E6, where `done`=1 and `start_mult`=0.
  - Total latency is 6 edges.
- Timeout: if no `done_mult` is sampled at E1..E(MULT_TIMEOUT), then `done`+`err` are registered at E(MULT_TIMEOUT).
- `done` is exactly one cycle wide.
- Minimum spacing between commands: `start` must be sampled low once in WAIT_LOW.
- `busy` is registered. It rises at E0 and falls at the edge that re-enters IDLE.
- `reset_n` asserted mid-MUL clears all outputs immediately (no clock needed). `start_mult` drops, and no `done` is produced for the aborted command.

## Test plan
- Add: A=8'hFF, B=8'h01, op=001 -> `done` one cycle after E0, `result`=16'h0100, `err`=0.
- Mul with the multiplier attached: A=8'hFF, B=8'hFF, op=100 -> `start_mult` high for 6 cycles, `done` at E6, `result`=16'hFE01. `mult_A`/`mult_B` stable throughout.
- Reserved opcode: op=110, A=8'h12 -> `done`=1, `err`=1, `result`=16'h0000 at E0. `start_mult` never asserts.
- Timeout: `done_mult` tied low, op=100 -> `done`=1, `err`=1, `result`=0 at E15. `start_mult` low at E15.
- Handshake: requester holds `start` high for 3 cycles after `done`. No second `done` and `busy` stays high until `start` is sampled low. Then a back-to-back xor with A=8'hF0, B=8'h3C gives `result`=16'h00CC.
- Reset mid-mul: `reset_n` pulled low at E3 -> `start_mult`, `busy`, `done` and `result` are 0 immediately. After release, a stray `done_mult` pulse gives no `done`, and a following add 2+3 returns 16'h0005.
